btn_conditioner: RTL and testbench

- Front-end input conditioner for the stopwatch top level. It receives the raw, asynchronous board buttons and switches and delivers clean, synchronous control signals to the stopwatch core.
- It synchronizes all four inputs and debounces the two push-buttons (pause, reset) into single-cycle press pulses.
- It keeps the paused/running toggle state, so the core sees a level `paused` plus a one-cycle `rst_pulse`.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 98 +++++++++
 rtl/btn_conditioner.sv | 91 +++++++++
 tb/tb_btn_conditioner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input front end: debounce state encoding
// and default/simulation timing constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  // 10 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // Short debounce window so benches reach acceptance in a few cycles
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: input synchronizer, debounce FSM with saturating
// stability counter, and a registered single-cycle press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  db_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   pulse_reg, pulse_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= DB_IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // The counter is compared before incrementing, so it tops out at CNT_MAX
  // and the state always leaves the wait state at that point.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      DB_IDLE: begin
        if (s) begin
          cnt_next   = CNT_ONE;
          state_next = DB_PRESS_WAIT;
        end
      end
      DB_PRESS_WAIT: begin
        if (!s) begin
          cnt_next   = '0;
          state_next = DB_IDLE;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          state_next = DB_PRESSED;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DB_PRESSED: begin
        if (!s) begin
          cnt_next   = CNT_ONE;
          state_next = DB_RELEASE_WAIT;
        end
      end
      DB_RELEASE_WAIT: begin
        if (s) begin
          cnt_next   = '0;
          state_next = DB_PRESSED;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          state_next = DB_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = DB_IDLE;
      end
    endcase
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Stopwatch input front end: debounced pause/reset press pulses, the paused
// toggle level, and synchronized slide switches.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause_raw,
  input  logic btn_rst_raw,
  input  logic sw_sel_raw,
  input  logic sw_adj_raw,
  output logic pause_pulse,
  output logic rst_pulse,
  output logic paused,
  output logic sel,
  output logic adj
);

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic [1:0] sw_raw;
  logic [1:0] sw_sync;
  logic       paused_reg, paused_next;

  assign btn_raw = {btn_rst_raw, btn_pause_raw};
  assign sw_raw  = {sw_adj_raw, sw_sel_raw};

  genvar gi;

  // Bit 0 = pause, bit 1 = reset; each button has its own independent FSM.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .SYNC_STAGES    (SYNC_STAGES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_raw[gi]),
        .pulse(btn_pulse[gi])
      );
    end
  endgenerate

  // Slide switches are level controls, so they are synchronized only.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sw
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_raw[gi]};
        end
      end

      assign sw_sync[gi] = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Reset press wins over a coinciding pause press.
  always_comb begin
    paused_next = paused_reg;
    if (btn_pulse[1]) begin
      paused_next = 1'b0;
    end else if (btn_pulse[0]) begin
      paused_next = ~paused_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      paused_reg <= 1'b0;
    end else begin
      paused_reg <= paused_next;
    end
  end

  assign pause_pulse = btn_pulse[0];
  assign rst_pulse   = btn_pulse[1];
  assign paused      = paused_reg;
  assign sel         = sw_sync[0];
  assign adj         = sw_sync[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed literal timing checks plus randomized
// bouncy stimulus compared every cycle against a run-length reference model.
module tb_btn_conditioner;
  import stopwatch_pkg::*;

  localparam int D = SIM_DEBOUNCE_CYCLES;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_pause_raw = 1'b0;
  logic btn_rst_raw = 1'b0;
  logic sw_sel_raw = 1'b0;
  logic sw_adj_raw = 1'b0;
  logic pause_pulse, rst_pulse, paused, sel, adj;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4),
    .SYNC_STAGES    (S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_pause_raw(btn_pause_raw),
    .btn_rst_raw  (btn_rst_raw),
    .sw_sel_raw   (sw_sel_raw),
    .sw_adj_raw   (sw_adj_raw),
    .pause_pulse  (pause_pulse),
    .rst_pulse    (rst_pulse),
    .paused       (paused),
    .sel          (sel),
    .adj          (adj)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Each input is delayed S samples; a button's accepted
  // level flips once D+1 consecutive delayed samples disagree with it.
  // Index 0 pause, 1 reset, 2 sel, 3 adj.
  bit pipe [4][S];
  bit acc  [2];
  int run  [2];
  bit m_pulse [2];
  bit m_paused;

  always @(posedge clk) begin
    bit raws [4];
    bit sv;
    bit np;
    raws = '{btn_pause_raw, btn_rst_raw, sw_sel_raw, sw_adj_raw};
    if (!reset) begin
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < S; i++) pipe[k][i] = 1'b0;
      for (int b = 0; b < 2; b++) begin
        acc[b] = 1'b0; run[b] = 0; m_pulse[b] = 1'b0;
      end
      m_paused = 1'b0;
    end else begin
      if (m_pulse[1]) m_paused = 1'b0;
      else if (m_pulse[0]) m_paused = !m_paused;
      for (int b = 0; b < 2; b++) begin
        sv = pipe[b][S-1];
        np = 1'b0;
        if (sv != acc[b]) begin
          run[b]++;
          if (run[b] == D + 1) begin
            acc[b] = sv;
            run[b] = 0;
            np = sv;
          end
        end else begin
          run[b] = 0;
        end
        m_pulse[b] = np;
      end
      for (int k = 0; k < 4; k++) begin
        for (int i = S - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = raws[k];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pause_pulse", pause_pulse, m_pulse[0]);
      chk("rst_pulse", rst_pulse, m_pulse[1]);
      chk("paused", paused, m_paused);
      chk("sel", sel, pipe[2][S-1]);
      chk("adj", adj, pipe[3][S-1]);
    end
  end

  initial begin
    int npulse;
    int both;
    int lvl [4];
    int hold [4];
    int rst_hold;

    // Reset phase
    reset = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pause_pulse", pause_pulse, 1'b0);
    chk("reset_rst_pulse", rst_pulse, 1'b0);
    chk("reset_paused", paused, 1'b0);
    chk("reset_sel", sel, 1'b0);
    chk("reset_adj", adj, 1'b0);

    // Clean press: raw high before edge 0, pulse only after edge 6
    reset = 1'b1;
    btn_pause_raw = 1'b1;
    sw_sel_raw = 1'b1;
    sw_adj_raw = 1'b1;
    npulse = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (pause_pulse === 1'b1) npulse++;
      if (k == 5 || k == 6 || k == 7) chk("clean_pulse_edge", pause_pulse, (k == 6));
      if (k == 6 || k == 7) chk("clean_paused_edge", paused, (k == 7));
      if (k == 3) begin
        chk("sel_pass", sel, 1'b1);
        chk("adj_pass", adj, 1'b1);
      end
    end
    btn_pause_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pause_pulse === 1'b1) npulse++;
    end
    chk("clean_single_pulse", (npulse == 1), 1'b1);
    chk("clean_paused_held", paused, 1'b1);

    // Both buttons together from paused=1: pulses coincide, reset wins
    btn_pause_raw = 1'b1;
    btn_rst_raw = 1'b1;
    both = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pause_pulse === 1'b1 && rst_pulse === 1'b1) both++;
    end
    chk("both_coincide", (both == 1), 1'b1);
    chk("both_paused_cleared", paused, 1'b0);
    btn_pause_raw = 1'b0;
    btn_rst_raw = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized bouncy inputs with occasional resets
    for (int i = 0; i < 4; i++) begin
      lvl[i] = 0;
      hold[i] = 0;
    end
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = $urandom_range(0, 1);
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 4);
        end
        hold[i]--;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        reset = 1'b0;
      end else begin
        reset = 1'b1;
        if ($urandom_range(0, 199) == 0) rst_hold = $urandom_range(1, 3);
      end
      btn_pause_raw = lvl[0][0];
      btn_rst_raw = lvl[1][0];
      sw_sel_raw = lvl[2][0];
      sw_adj_raw = lvl[3][0];
    end
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
